seg_scan_decoder: RTL
=====================

SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 Parameter STABLE_CYCLES, default 4: consecutive identical synchronised samples of an_in/seg_in required before a digit is captured.
REQ-002 Parameter TIMEOUT_CYCLES, default 1_000_000: cycles without any capture before the partial frame is discarded.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1: rising-edge clock for all state.
REQ-005 rst_n  input  1: asynchronous active-low reset.
REQ-006 seg_in  input  7: active-low segments, seg_in[0]=a through seg_in[6]=g.
REQ-007 an_in  input  8: active-low digit enables; an_in[i]=0 selects digit i.
REQ-008 value  output  32: last published frame; digit i occupies value[4i+3:4i].
REQ-009 digit_ok  output  8: bit i set when digit i of the published frame decoded to a hex glyph.
REQ-010 blank  output  8: bit i set when digit i of the published frame was all segments off (seg_in=7'b1111111).
REQ-011 frame_valid  output  1: single-cycle pulse when value, digit_ok and blank update.
REQ-012 err  output  1: sticky; set when any capture in the current frame was neither a hex glyph nor blank.
REQ-013 stale  output  1: high when a timeout discarded a partial frame; cleared on the next frame_valid.

Function
REQ-014 seg_in and an_in SHALL each pass through a 2-flop synchroniser; all later timing counts from synchronised values.
REQ-015 Glyphs (bits g..a, active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-016 FSM states IDLE, SETTLE, HOLD.
REQ-017 IDLE: an_in not exactly one zero bit; stability counter held at 0; no capture.
REQ-018 IDLE->SETTLE when an_in has exactly one zero bit; counter starts at 1.
REQ-019 SETTLE: counter increments each cycle inputs equal the previous sample; any change restarts at 1, or goes to IDLE if an_in is no longer one-hot.
REQ-020 SETTLE->HOLD on the edge where the counter reaches STABLE_CYCLES; that edge captures the nibble, ok bit and blank bit for the selected digit and sets its mask bit.
REQ-021 HOLD: no further capture until an_in or seg_in changes, then to SETTLE (one-hot) or IDLE (otherwise).
REQ-022 Unrecognised non-blank pattern: nibble 0, ok=0, blank=0, err set.
REQ-023 Blank: nibble 0, ok=0, blank=1; err unaffected.
REQ-024 Re-capture of an already-masked digit SHALL overwrite its shadow entry without affecting the mask.
REQ-025 When the mask reaches 8'hFF, shadow registers SHALL copy to outputs, frame_valid pulses on the following cycle, and mask clears; err is then cleared after publication.
REQ-026 Idle counter counts cycles since the last capture; on reaching TIMEOUT_CYCLES the mask and err clear, stale sets, counter resets; published outputs are retained.
REQ-027 Capture and timeout on the same edge: capture wins and the counter resets.
REQ-028 Capture-to-frame_valid latency: exactly 1 cycle; input-to-capture minimum latency: 2 + STABLE_CYCLES cycles.

Reset
REQ-029 rst_n low SHALL immediately force state IDLE and zero value, digit_ok, blank, frame_valid, err, stale, mask, shadows, counters and synchronisers (synchronisers reset to 1s, i.e. inactive).
REQ-030 Reset mid-frame SHALL discard the partial frame without a frame_valid.

Structure
REQ-031 Shared package SHALL hold the FSM state enum, the 16-entry glyph table and the BLANK constant.
REQ-032 Sub-module seg_glyph_decode (combinational pattern-to-nibble/ok/blank) SHALL be instantiated once.

Verification
REQ-033 Scan digits 0..7 showing 8,7,6,5,4,3,2,1 (digit0=1), each held 10 cycles -> one frame_valid, value=32'h87654321, digit_ok=8'hFF, err=0.
REQ-034 Digit 3 driven 7'b1111111 -> blank=8'h08, digit_ok=8'hF7, value[15:12]=0.
REQ-035 Digit 5 driven 7'b1010101 -> err=1, digit_ok[5]=0 at frame_valid; err=0 after the next clean frame.
REQ-036 Each digit held only 3 cycles (STABLE_CYCLES=4) -> no capture, no frame_valid.
REQ-037 Scan 4 digits then stop for TIMEOUT_CYCLES (set to 100) -> stale=1, value unchanged; subsequent full scan -> frame_valid, stale=0.
REQ-038 Assert rst_n low after 6 digits captured -> no frame_valid; all outputs 0 during reset; next full scan publishes correctly.

Source files
------------

// File: rtl/seg_scan_decoder_pkg.sv
// Shared types and constants for the seven-segment scan decoder.
package seg_scan_decoder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_e;

  // All segments off (active-low, bits g..a).
  localparam logic [6:0] BLANK = 7'b1111111;

  // Hex glyphs, bits g..a active-low; entry n is the pattern for nibble n.
  localparam logic [15:0][6:0] GLYPH_TABLE = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  // True when exactly one digit enable is asserted (low).
  function automatic logic an_onehot(input logic [7:0] an);
    return ($countones(~an) == 1);
  endfunction

  // Position of the asserted (low) digit enable.
  function automatic logic [2:0] an_index(input logic [7:0] an);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (!an[i[2:0]]) idx = i[2:0];
    end
    return idx;
  endfunction

endpackage

// File: rtl/seg_scan_decoder_glyph_decode.sv
// Combinational segment-pattern to nibble decoder.
module seg_glyph_decode
  import seg_scan_decoder_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] nibble_o,
  output logic       ok_o,
  output logic       blank_o
);

  // Look the pattern up in the glyph table; unknown patterns decode to 0.
  always_comb begin
    nibble_o = 4'd0;
    ok_o     = 1'b0;
    blank_o  = (seg_i == BLANK);
    for (int i = 0; i < 16; i++) begin
      if (seg_i == GLYPH_TABLE[i[3:0]]) begin
        nibble_o = i[3:0];
        ok_o     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Recovers an 8-digit hex value by sniffing a multiplexed seven-segment bus.
module seg_scan_decoder
  import seg_scan_decoder_pkg::*;
#(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  seg_in,
  input  logic [7:0]  an_in,
  output logic [31:0] value,
  output logic [7:0]  digit_ok,
  output logic [7:0]  blank,
  output logic        frame_valid,
  output logic        err,
  output logic        stale
);

  localparam int CNT_W  = $clog2(STABLE_CYCLES + 1);
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  // With a threshold of one, the first one-hot sample is already stable.
  localparam bit RESTART_HITS = (STABLE_CYCLES <= 1);

  logic [7:0]        an_s1_q, an_s2_q, samp_an_q;
  logic [6:0]        seg_s1_q, seg_s2_q, samp_seg_q;
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic [7:0]        mask_q, mask_d, sh_ok_q, sh_ok_d, sh_blank_q, sh_blank_d;
  logic [31:0]       sh_val_q, sh_val_d, value_q, value_d;
  logic [7:0]        ok_q, ok_d, blank_q, blank_d;
  logic              fv_q, fv_d, err_q, err_d, stale_q, stale_d;
  logic              capture, same, onehot;
  logic [2:0]        cap_idx;
  logic [3:0]        dec_nibble;
  logic              dec_ok, dec_blank;

  assign same    = (an_s2_q == samp_an_q) && (seg_s2_q == samp_seg_q);
  assign onehot  = an_onehot(an_s2_q);
  assign cap_idx = an_index(an_s2_q);
  assign cnt_inc = cnt_q + CNT_W'(1);

  seg_glyph_decode u_decode (
    .seg_i    (seg_s2_q),
    .nibble_o (dec_nibble),
    .ok_o     (dec_ok),
    .blank_o  (dec_blank)
  );

  // Two-flop synchronisers plus a one-cycle-old copy used for stability checks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_s1_q    <= '1;
      an_s2_q    <= '1;
      seg_s1_q   <= '1;
      seg_s2_q   <= '1;
      samp_an_q  <= '1;
      samp_seg_q <= '1;
    end else begin
      an_s1_q    <= an_in;
      an_s2_q    <= an_s1_q;
      seg_s1_q   <= seg_in;
      seg_s2_q   <= seg_s1_q;
      samp_an_q  <= an_s2_q;
      samp_seg_q <= seg_s2_q;
    end
  end

  // Settle FSM: count identical samples and flag the capture edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (onehot) begin
          state_d = RESTART_HITS ? HOLD : SETTLE;
          cnt_d   = CNT_W'(1);
          capture = RESTART_HITS;
        end
      end
      SETTLE: begin
        if (!same) begin
          if (onehot) begin
            state_d = RESTART_HITS ? HOLD : SETTLE;
            cnt_d   = CNT_W'(1);
            capture = RESTART_HITS;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_W'(STABLE_CYCLES)) begin
            state_d = HOLD;
            capture = 1'b1;
          end
        end
      end
      HOLD: begin
        if (!same) begin
          if (onehot) begin
            state_d = RESTART_HITS ? HOLD : SETTLE;
            cnt_d   = CNT_W'(1);
            capture = RESTART_HITS;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Frame assembly: publish, error clear, timeout, then capture (capture wins).
  always_comb begin
    mask_d     = mask_q;
    sh_val_d   = sh_val_q;
    sh_ok_d    = sh_ok_q;
    sh_blank_d = sh_blank_q;
    value_d    = value_q;
    ok_d       = ok_q;
    blank_d    = blank_q;
    fv_d       = 1'b0;
    err_d      = err_q;
    stale_d    = stale_q;
    idle_d     = idle_q;
    if (mask_q == 8'hFF) begin
      value_d = sh_val_q;
      ok_d    = sh_ok_q;
      blank_d = sh_blank_q;
      fv_d    = 1'b1;
      stale_d = 1'b0;
      mask_d  = '0;
    end
    // err stays visible alongside the frame_valid pulse, then starts afresh.
    if (fv_q) err_d = 1'b0;
    // The idle counter only runs while a partial frame is pending.
    if (mask_q == '0 || mask_q == 8'hFF) begin
      idle_d = '0;
    end else if (idle_q == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
      idle_d  = '0;
      mask_d  = '0;
      err_d   = 1'b0;
      stale_d = 1'b1;
    end else begin
      idle_d = idle_q + IDLE_W'(1);
    end
    if (capture) begin
      sh_val_d[{cap_idx, 2'b00} +: 4] = dec_nibble;
      sh_ok_d[cap_idx]    = dec_ok;
      sh_blank_d[cap_idx] = dec_blank;
      mask_d[cap_idx]     = 1'b1;
      if (!dec_ok && !dec_blank) err_d = 1'b1;
      idle_d = '0;
    end
  end

  // State, frame and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idle_q     <= '0;
      mask_q     <= '0;
      sh_val_q   <= '0;
      sh_ok_q    <= '0;
      sh_blank_q <= '0;
      value_q    <= '0;
      ok_q       <= '0;
      blank_q    <= '0;
      fv_q       <= 1'b0;
      err_q      <= 1'b0;
      stale_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idle_q     <= idle_d;
      mask_q     <= mask_d;
      sh_val_q   <= sh_val_d;
      sh_ok_q    <= sh_ok_d;
      sh_blank_q <= sh_blank_d;
      value_q    <= value_d;
      ok_q       <= ok_d;
      blank_q    <= blank_d;
      fv_q       <= fv_d;
      err_q      <= err_d;
      stale_q    <= stale_d;
    end
  end

  assign value       = value_q;
  assign digit_ok    = ok_q;
  assign blank       = blank_q;
  assign frame_valid = fv_q;
  assign err         = err_q;
  assign stale       = stale_q;

endmodule
